// File: rtl/chi_link_pkg.sv
// chi_link_pkg: shared types and constants for the CHI link-layer controller.
//   link_state_e : four-state LINKACTIVE handshake encoding (CHI order)
//   CH_REQ..CH_SNP : bit index of each channel in per-channel vectors
//   CRD_W        : width of one L-credit counter
package chi_link_pkg;

  localparam int unsigned CHI_MAX_CRD = 15;
  localparam int unsigned CRD_W       = $clog2(CHI_MAX_CRD + 1);

  localparam int unsigned CH_REQ = 0;
  localparam int unsigned CH_RSP = 1;
  localparam int unsigned CH_DAT = 2;
  localparam int unsigned CH_SNP = 3;

  typedef enum logic [1:0] {
    STOP       = 2'd0,
    ACTIVATE   = 2'd1,
    RUN        = 2'd2,
    DEACTIVATE = 2'd3
  } link_state_e;

endpackage

// File: rtl/chi_link_crd_cnt.sv
// chi_link_crd_cnt: single-channel up/down L-credit counter that saturates
// at 0 and MAX instead of wrapping.
//   clk, rst : clock, async active-high reset (count clears to 0)
//   inc, dec : one credit in / one credit out this cycle
//   cnt      : registered credit count
//   ovf_c    : increment attempted at MAX (count held)
//   udf_c    : decrement attempted at 0 (count held)
module chi_link_crd_cnt
  import chi_link_pkg::*;
#(
  parameter int unsigned MAX = CHI_MAX_CRD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CRD_W-1:0] cnt,
  output logic             ovf_c,
  output logic             udf_c
);

  // Simultaneous inc and dec cancel, so neither can be an error.
  always_comb begin
    ovf_c = inc & ~dec & (cnt == CRD_W'(MAX));
    udf_c = dec & ~inc & (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc & ~dec & ~ovf_c) begin
      cnt <= cnt + CRD_W'(1);
    end else if (dec & ~inc & ~udf_c) begin
      cnt <= cnt - CRD_W'(1);
    end
  end

endmodule

// File: rtl/chi_link_ctrl.sv
// chi_link_ctrl: CHI link-layer controller for one ring node port.
// Runs the TX and RX LINKACTIVE handshakes and the per-channel L-credit
// accounting (TX credits held, RX credits outstanding, RX buffer space).
// Optional error checking: define CHI_LINK_CTRL_ERR_CHK_EN to enable the
// sticky err output and simulation assertions; otherwise err is tied 0.
//   clk, rst             : clock, async active-high reset
//   link_en              : local request to bring the TX link up/down
//   TXLINKACTIVEREQ/ACK  : TX handshake (REQ out, ACK in)
//   RXLINKACTIVEREQ/ACK  : RX handshake (REQ in, ACK out)
//   TXSACTIVE            : TX FSM not in STOP
//   tx_lcrdv             : credit received from partner, per channel
//   tx_flit_sent         : protocol flit sent (consumes a credit)
//   tx_crd_avail         : channel has a credit and TX is in RUN
//   tx_rtn_req/tx_rtn_ack: LCrdReturn request to datapath / sent
//   tx_link_run          : TX FSM in RUN
//   rx_flitv             : flit received (consumes an outstanding credit)
//   rx_buf_free          : one receive buffer entry freed
//   RXLCRDV              : credit grant to partner
//   err                  : sticky protocol/credit error
module chi_link_ctrl
  import chi_link_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned MAX_CRD      = CHI_MAX_CRD,
  parameter int unsigned RX_BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              link_en,
  output logic              TXLINKACTIVEREQ,
  input  logic              TXLINKACTIVEACK,
  input  logic              RXLINKACTIVEREQ,
  output logic              RXLINKACTIVEACK,
  output logic              TXSACTIVE,
  input  logic [NUM_CH-1:0] tx_lcrdv,
  input  logic [NUM_CH-1:0] tx_flit_sent,
  output logic [NUM_CH-1:0] tx_crd_avail,
  output logic [NUM_CH-1:0] tx_rtn_req,
  input  logic [NUM_CH-1:0] tx_rtn_ack,
  output logic              tx_link_run,
  input  logic [NUM_CH-1:0] rx_flitv,
  input  logic [NUM_CH-1:0] rx_buf_free,
  output logic [NUM_CH-1:0] RXLCRDV,
  output logic              err
);

  link_state_e tx_state;
  link_state_e rx_state;

  logic [CRD_W-1:0] tx_cnt  [NUM_CH];
  logic [CRD_W-1:0] rx_outs [NUM_CH];
  logic [CRD_W-1:0] rx_pend [NUM_CH];

  logic [NUM_CH-1:0] tx_dec;
  logic [NUM_CH-1:0] tx_ovf;
  logic [NUM_CH-1:0] tx_udf;
  logic [NUM_CH-1:0] tx_bad_send;
  logic [NUM_CH-1:0] tx_nz;
  logic [NUM_CH-1:0] rx_ovf;
  logic [NUM_CH-1:0] rx_udf;
  logic [NUM_CH-1:0] rx_bad_flit;
  logic [NUM_CH-1:0] rx_nz;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] pend_ovf;
  logic [NUM_CH-1:0] ch_err;

  // Flits sent outside RUN are illegal and do not consume a credit.
  assign tx_dec      = tx_rtn_ack | (tx_flit_sent & {NUM_CH{tx_state == RUN}});
  assign tx_bad_send = tx_flit_sent & ~{NUM_CH{tx_state == RUN}};

  assign tx_crd_avail = {NUM_CH{tx_state == RUN}} & tx_nz;
  assign tx_rtn_req   = {NUM_CH{tx_state == DEACTIVATE}} & tx_nz;

  // Per-channel credit counters: TX credits held, RX credits outstanding.
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    chi_link_crd_cnt #(.MAX(MAX_CRD)) u_tx_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (tx_lcrdv[g]),
      .dec   (tx_dec[g]),
      .cnt   (tx_cnt[g]),
      .ovf_c (tx_ovf[g]),
      .udf_c (tx_udf[g])
    );

    chi_link_crd_cnt #(.MAX(MAX_CRD)) u_rx_outs (
      .clk   (clk),
      .rst   (rst),
      .inc   (grant[g]),
      .dec   (rx_flitv[g]),
      .cnt   (rx_outs[g]),
      .ovf_c (rx_ovf[g]),
      .udf_c (rx_udf[g])
    );
  end

  // Grant decision uses current counters; RXLCRDV is its registered copy.
  always_comb begin
    tx_nz       = '0;
    rx_nz       = '0;
    grant       = '0;
    pend_ovf    = '0;
    rx_bad_flit = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      tx_nz[c]       = (tx_cnt[c] != '0);
      rx_nz[c]       = (rx_outs[c] != '0);
      grant[c]       = (rx_state == RUN) & (rx_pend[c] != '0) &
                       (rx_outs[c] != CRD_W'(MAX_CRD));
      pend_ovf[c]    = rx_buf_free[c] & ~grant[c] &
                       (rx_pend[c] == CRD_W'(RX_BUF_DEPTH));
      rx_bad_flit[c] = rx_flitv[c] & (rx_outs[c] == '0);
    end
  end

  assign ch_err = tx_ovf | tx_udf | tx_bad_send | rx_ovf | rx_udf |
                  rx_bad_flit | pend_ovf;

  // Free receive buffer entries not yet granted to the partner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(NUM_CH); c++) rx_pend[c] <= CRD_W'(RX_BUF_DEPTH);
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (rx_buf_free[c] & ~grant[c] & ~pend_ovf[c]) begin
          rx_pend[c] <= rx_pend[c] + CRD_W'(1);
        end else if (grant[c] & ~rx_buf_free[c]) begin
          rx_pend[c] <= rx_pend[c] - CRD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) RXLCRDV <= '0;
    else     RXLCRDV <= grant;
  end

  // TX handshake FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state        <= STOP;
      TXLINKACTIVEREQ <= 1'b0;
      TXSACTIVE       <= 1'b0;
      tx_link_run     <= 1'b0;
    end else begin
      case (tx_state)
        STOP: begin
          if (link_en) begin
            tx_state        <= ACTIVATE;
            TXLINKACTIVEREQ <= 1'b1;
            TXSACTIVE       <= 1'b1;
          end
        end
        ACTIVATE: begin
          if (TXLINKACTIVEACK) begin
            tx_state    <= RUN;
            tx_link_run <= 1'b1;
          end
        end
        RUN: begin
          if (!link_en) begin
            tx_state        <= DEACTIVATE;
            TXLINKACTIVEREQ <= 1'b0;
            tx_link_run     <= 1'b0;
          end
        end
        DEACTIVATE: begin
          // link_en is ignored here: the link must fully reach STOP first.
          if ((tx_nz == '0) && !TXLINKACTIVEACK) begin
            tx_state  <= STOP;
            TXSACTIVE <= 1'b0;
          end
        end
        default: tx_state <= STOP;
      endcase
    end
  end

  // RX handshake FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state        <= STOP;
      RXLINKACTIVEACK <= 1'b0;
    end else begin
      case (rx_state)
        STOP: begin
          if (RXLINKACTIVEREQ) rx_state <= ACTIVATE;
        end
        ACTIVATE: begin
          rx_state        <= RUN;
          RXLINKACTIVEACK <= 1'b1;
        end
        RUN: begin
          if (!RXLINKACTIVEREQ) rx_state <= DEACTIVATE;
        end
        DEACTIVATE: begin
          if (rx_nz == '0) begin
            rx_state        <= STOP;
            RXLINKACTIVEACK <= 1'b0;
          end
        end
        default: rx_state <= STOP;
      endcase
    end
  end

`ifdef CHI_LINK_CTRL_ERR_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (|ch_err) err <= 1'b1;
  end

  // Name the offending channel in simulation.
  always @(posedge clk) begin
    if (!rst) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        assert (!ch_err[c])
          else $warning("chi_link_ctrl: credit/protocol error on channel %0d", c);
      end
    end
  end
`else
  logic unused_err;
  assign unused_err = |ch_err;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_chi_link_ctrl.sv
// tb_chi_link_ctrl: directed self-checking bench for chi_link_ctrl.
// Covers reset state, TX bring-up/credit use/deactivation with credit return,
// RX bring-up/grants/deactivation and an asynchronous reset mid-RUN.
module tb_chi_link_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       link_en;
  logic       TXLINKACTIVEREQ;
  logic       TXLINKACTIVEACK;
  logic       RXLINKACTIVEREQ;
  logic       RXLINKACTIVEACK;
  logic       TXSACTIVE;
  logic [3:0] tx_lcrdv;
  logic [3:0] tx_flit_sent;
  logic [3:0] tx_crd_avail;
  logic [3:0] tx_rtn_req;
  logic [3:0] tx_rtn_ack;
  logic       tx_link_run;
  logic [3:0] rx_flitv;
  logic [3:0] rx_buf_free;
  logic [3:0] RXLCRDV;
  logic       err;

  logic [16:0] all_outs;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          gcnt [4];
  int          nret;
  logic        err_exp;

  assign all_outs = {TXLINKACTIVEREQ, RXLINKACTIVEACK, TXSACTIVE, tx_link_run, err,
                     tx_crd_avail, tx_rtn_req, RXLCRDV};

  always #5 clk = ~clk;

  chi_link_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .link_en         (link_en),
    .TXLINKACTIVEREQ (TXLINKACTIVEREQ),
    .TXLINKACTIVEACK (TXLINKACTIVEACK),
    .RXLINKACTIVEREQ (RXLINKACTIVEREQ),
    .RXLINKACTIVEACK (RXLINKACTIVEACK),
    .TXSACTIVE       (TXSACTIVE),
    .tx_lcrdv        (tx_lcrdv),
    .tx_flit_sent    (tx_flit_sent),
    .tx_crd_avail    (tx_crd_avail),
    .tx_rtn_req      (tx_rtn_req),
    .tx_rtn_ack      (tx_rtn_ack),
    .tx_link_run     (tx_link_run),
    .rx_flitv        (rx_flitv),
    .rx_buf_free     (rx_buf_free),
    .RXLCRDV         (RXLCRDV),
    .err             (err)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic count_grants(input int cycles);
    for (int c = 0; c < 4; c++) gcnt[c] = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      for (int c = 0; c < 4; c++) gcnt[c] += int'(RXLCRDV[c]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; link_en = 1'b0; TXLINKACTIVEACK = 1'b0; RXLINKACTIVEREQ = 1'b0;
    tx_lcrdv = '0; tx_flit_sent = '0; tx_rtn_ack = '0; rx_flitv = '0; rx_buf_free = '0;
    err_exp = 1'b0;
    step(2);
    chk("reset_outputs", 32'(all_outs), 32'h0);
    rst = 1'b0;
    step(1);
    chk("idle_after_reset", 32'(all_outs), 32'h0);

    // TX bring-up: REQ one cycle after link_en, credits counted in ACTIVATE.
    link_en = 1'b1;
    step(1);
    chk("tx_req_cycle1", 32'({TXLINKACTIVEREQ, TXSACTIVE, tx_link_run}), 32'b110);
    tx_lcrdv = 4'b0101;
    step(1);
    chk("tx_avail_gated_in_activate", 32'(tx_crd_avail), 32'h0);
    TXLINKACTIVEACK = 1'b1;
    step(1);
    chk("tx_run_after_ack", 32'(tx_link_run), 32'h1);
    step(1);
    tx_lcrdv = 4'b0001;
    step(1);
    tx_lcrdv = 4'b0000;
    chk("tx_avail_req_dat", 32'(tx_crd_avail), 32'b0101);

    // Send REQ down to zero: still available after 3 sends, gone after 4.
    tx_flit_sent = 4'b0001;
    step(3);
    chk("tx_avail_after_3_sends", 32'(tx_crd_avail), 32'b0101);
    step(1);
    tx_flit_sent = 4'b0000;
    chk("tx_avail_after_4_sends", 32'(tx_crd_avail), 32'b0100);
    chk("err_clear_before_5th", 32'(err), 32'h0);

    // Simultaneous credit in and send on DAT leaves its count at 3.
    tx_lcrdv = 4'b0100; tx_flit_sent = 4'b0100;
    step(1);
    tx_lcrdv = 4'b0000; tx_flit_sent = 4'b0000;

    // Fifth send on REQ with no credit.
    tx_flit_sent = 4'b0001;
    step(1);
    tx_flit_sent = 4'b0000;
`ifdef CHI_LINK_CTRL_ERR_CHK_EN
    err_exp = 1'b1;
`endif
    chk("err_after_5th_send", 32'(err), 32'(err_exp));
    chk("tx_avail_req_stays_0", 32'(tx_crd_avail), 32'b0100);

    // TX deactivate: DAT returns exactly 3 credits.
    link_en = 1'b0;
    step(1);
    chk("tx_deact_outputs", 32'({TXLINKACTIVEREQ, TXSACTIVE, tx_link_run}), 32'b010);
    chk("tx_rtn_req_dat", 32'(tx_rtn_req), 32'b0100);
    chk("tx_avail_off_in_deact", 32'(tx_crd_avail), 32'h0);
    nret = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_rtn_req[2] !== 1'b1) break;
      tx_rtn_ack = 4'b0100;
      step(1);
      nret++;
    end
    tx_rtn_ack = 4'b0000;
    chk("tx_return_count", 32'(nret), 32'd3);
    chk("tx_rtn_req_cleared", 32'(tx_rtn_req), 32'h0);
    link_en = 1'b1;   // must be ignored until STOP
    step(2);
    chk("tx_wait_partner_ack", 32'({TXLINKACTIVEREQ, TXSACTIVE}), 32'b01);
    TXLINKACTIVEACK = 1'b0;
    step(1);
    link_en = 1'b0;
    chk("tx_stop_reached", 32'({TXLINKACTIVEREQ, TXSACTIVE, tx_link_run}), 32'b000);

    // RX bring-up: ACTIVATE for one cycle, ack registered, then 4 grants each.
    RXLINKACTIVEREQ = 1'b1;
    step(2);
    chk("rx_ack_up", 32'({RXLINKACTIVEACK, RXLCRDV}), 32'b1_0000);
    count_grants(8);
    for (int c = 0; c < 4; c++) chk($sformatf("rx_grants_ch%0d", c), 32'(gcnt[c]), 32'd4);
    chk("rx_no_more_grants", 32'(RXLCRDV), 32'h0);
    rx_buf_free = 4'b0010;
    step(1);
    rx_buf_free = 4'b0000;
    chk("rx_grant_not_yet", 32'(RXLCRDV), 32'h0);
    step(1);
    chk("rx_grant_after_free", 32'(RXLCRDV), 32'b0010);
    step(1);
    chk("rx_single_grant", 32'(RXLCRDV), 32'h0);

    // Consume down to 2 outstanding per channel, then drop REQ.
    rx_flitv = 4'b1111;
    step(2);
    rx_flitv = 4'b0010;
    step(1);
    rx_flitv = 4'b0000;
    RXLINKACTIVEREQ = 1'b0;
    step(1);
    chk("rx_ack_held_deact", 32'(RXLINKACTIVEACK), 32'h1);
    rx_flitv = 4'b1111;
    step(1);
    chk("rx_ack_held_1_left", 32'(RXLINKACTIVEACK), 32'h1);
    step(1);
    rx_flitv = 4'b0000;
    chk("rx_ack_held_0_left", 32'(RXLINKACTIVEACK), 32'h1);
    step(1);
    chk("rx_ack_dropped", 32'(RXLINKACTIVEACK), 32'h0);
    chk("err_after_rx", 32'(err), 32'(err_exp));

    // Bring both sides up with nonzero counters, then reset mid-RUN.
    link_en = 1'b1; TXLINKACTIVEACK = 1'b1; tx_lcrdv = 4'b0010;
    RXLINKACTIVEREQ = 1'b1; rx_buf_free = 4'b1111;
    step(1);
    rx_buf_free = 4'b0000;
    step(1);
    tx_lcrdv = 4'b0000;
    step(1);
    chk("pre_reset_state", 32'({RXLINKACTIVEACK, tx_link_run, tx_crd_avail, RXLCRDV}),
        32'b1_1_0010_1111);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(all_outs), 32'h0);
    link_en = 1'b0; TXLINKACTIVEACK = 1'b0; RXLINKACTIVEREQ = 1'b0;
    step(1);
    rst = 1'b0;
    link_en = 1'b1; TXLINKACTIVEACK = 1'b1; RXLINKACTIVEREQ = 1'b1;
    step(2);
    chk("tx_cnt_cleared", 32'({tx_link_run, tx_crd_avail}), 32'b1_0000);
    count_grants(7);
    for (int c = 0; c < 4; c++) chk($sformatf("rx_pend_restored_ch%0d", c), 32'(gcnt[c]), 32'd4);
    chk("err_cleared_by_reset", 32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
